pc_stack_seq: RTL and testbench
===============================

# pc_stack_seq

Parametrised next-generation program counter for the processor fetch stage. It supports sequential increment, signed relative branches, absolute jumps, and hardware call/return through an internal return-address stack of configurable depth. It also has a stall input and sticky stack overflow/underflow flags. It drives the instruction-memory address each cycle and takes jump operands from the 8-bit data path and the control decoder.

## Interface
- D, 12, program counter width in bits
- DW, 8, width of the data-path operand `inB`
- SD, 4, return-stack depth in entries (≥1)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold all state this cycle
- reljump_en  input  1  relative branch request
- absjump_en  input  1  absolute jump request
- call_en  input  1  call: push return address, then jump absolute
- ret_en  input  1  return: pop return address into PC
- target  input  D  signed two's-complement relative offset
- inB  input  DW  absolute jump/call destination from data path
- prog_ctr  output  D  current program counter
- stack_depth  output  $clog2(SD+1)  number of valid stack entries
- stack_ovf  output  1  sticky flag: call issued while stack full
- stack_unf  output  1  sticky flag: return issued while stack empty

## Operation
- Abs operand: `inB` is zero-extended to D bits when DW<D and truncated to its low D bits when DW>D. Call this `abs`.
- All PC arithmetic is modulo 2^D, so wrap-around is silent.
- Next-PC priority, evaluated on each rising edge:
  1. reset: prog_ctr=0, stack_depth=0, stack_ovf=0, stack_unf=0. Stack contents are don't-care.
  2. stall: every register holds and all enables are ignored.
  3. ret_en:
     - If depth>0: PC ← top entry, then depth−1.
     - If depth==0: PC ← PC+1 and stack_unf←1.
  4. call_en:
     - If depth<SD: push PC+1, then PC ← abs and depth+1.
     - If depth==SD: no push, PC ← abs, stack_ovf←1. The stack is unchanged.
  5. absjump_en: PC ← abs.
  6. reljump_en: PC ← PC + target, with target sign-extended to D bits.
  7. Otherwise: PC ← PC+1.
- Simultaneous enables resolve strictly by the priority above. Lower-priority requests are dropped, not queued.
- Stack storage is an SD-entry register array with a push/pop pointer. Top of stack is entry depth−1.
- stack_ovf and stack_unf, once set, clear only on reset.

## Timing
- Every request takes effect on prog_ctr at the first rising edge after it is sampled high, with no extra pipeline latency.
- stack_depth and both flags update on the same edge as prog_ctr.
- All outputs are registered. There is no combinational path from any input to any output.
- Reset mid-call or mid-return wins that cycle outright. The stack empties and the pending request is discarded.
- A return on the cycle immediately after a call returns to the just-pushed address.
- Back-to-back calls and returns sustain one operation per cycle.

## Test plan
- Reset then free-run 5 cycles → prog_ctr 0,1,2,3,4,5. depth=0 and both flags=0. Then hold stall for 3 cycles → prog_ctr stays 5.
- PC=10 with reljump_en and target=0xFFD (−3) → PC=7. Then PC=0xFFF with increment → wraps to 0.
- PC=20 with call_en and inB=0x40 → PC=0x40, depth=1. Run 2 cycles (0x41, 0x42), then ret_en → PC=21, depth=0.
- SD=4: issue 5 nested calls to inB=0x10..0x14 starting at PC=1:
  - Required after all five: PC=0x14, depth=4, stack_ovf=1.
  - Then 4 returns: PCs 0x13 (from the entry pushed at PC=0x12), 0x12, 0x11, 2.
  - Then a 5th return → PC=3, stack_unf=1.
- Assert reljump_en, absjump_en, call_en and ret_en together with depth=1 and top entry=0x30 → PC=0x30 (return wins), depth=0. Repeat with ret_en low → call wins.
- With depth=2, assert reset and call_en together → PC=0, depth=0, flags=0. A following ret_en gives PC=1 and stack_unf=1.

Source files
------------

// File: rtl/pc_stack_seq.sv
// Program counter with relative/absolute jumps and hardware call/return through
// a small return-address stack with sticky overflow/underflow flags.
module pc_stack_seq #(
  parameter int unsigned D    = 12,
  parameter int unsigned DW   = 8,
  parameter int unsigned SD   = 4,
  localparam int unsigned DepW = $clog2(SD + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            reljump_en,
  input  logic            absjump_en,
  input  logic            call_en,
  input  logic            ret_en,
  input  logic [D-1:0]    target,
  input  logic [DW-1:0]   inB,
  output logic [D-1:0]    prog_ctr,
  output logic [DepW-1:0] stack_depth,
  output logic            stack_ovf,
  output logic            stack_unf
);

  localparam int unsigned PtrW = (SD > 1) ? $clog2(SD) : 1;
  localparam int unsigned XW   = (D > DW) ? D : DW;

  logic [D-1:0]    pc_q, pc_d, pc_inc, abs_val;
  logic [DepW-1:0] depth_q, depth_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            push;
  logic [D-1:0]    stk_q [SD];
  logic [XW-1:0]   inb_ext;
  logic [PtrW-1:0] top_idx, push_idx;

  // Zero-extend or truncate the data-path operand to PC width.
  assign inb_ext  = XW'(inB);
  assign abs_val  = inb_ext[D-1:0];
  assign pc_inc   = pc_q + D'(1);
  assign top_idx  = PtrW'(depth_q - DepW'(1));
  assign push_idx = PtrW'(depth_q);

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (!stall) begin
      if (ret_en) begin
        if (depth_q != '0) begin
          pc_d    = stk_q[top_idx];
          depth_d = depth_q - DepW'(1);
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (call_en) begin
        pc_d = abs_val;
        if (depth_q == DepW'(SD)) begin
          ovf_d = 1'b1;
        end else begin
          push    = 1'b1;
          depth_d = depth_q + DepW'(1);
        end
      end else if (absjump_en) begin
        pc_d = abs_val;
      end else if (reljump_en) begin
        pc_d = pc_q + target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entries need no reset; only depth decides what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      stk_q[push_idx] <= pc_inc;
    end
  end

  assign prog_ctr    = pc_q;
  assign stack_depth = depth_q;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;

endmodule

// File: tb/tb_pc_stack_seq.sv
// Directed bench for pc_stack_seq: queue-based reference model compared every
// cycle, plus literal expectations at key points of the sequence.
module tb_pc_stack_seq;

  localparam int unsigned D  = 12;
  localparam int unsigned DW = 8;
  localparam int unsigned SD = 4;

  logic          clk = 1'b0;
  logic          reset, stall, reljump_en, absjump_en, call_en, ret_en;
  logic [D-1:0]  target;
  logic [DW-1:0] inB;
  logic [D-1:0]  prog_ctr;
  logic [2:0]    stack_depth;
  logic          stack_ovf, stack_unf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int       m_pc;
  int       m_stack [$];
  bit       m_ovf, m_unf, m_valid = 1'b0;

  pc_stack_seq #(.D(D), .DW(DW), .SD(SD)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .reljump_en (reljump_en),
    .absjump_en (absjump_en),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .target     (target),
    .inB        (inB),
    .prog_ctr   (prog_ctr),
    .stack_depth(stack_depth),
    .stack_ovf  (stack_ovf),
    .stack_unf  (stack_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int t;
    if (reset) begin
      m_pc = 0;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid && !stall) begin
      if (ret_en) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin
          m_pc = (m_pc + 1) % 4096;
          m_unf = 1'b1;
        end
      end else if (call_en) begin
        if (m_stack.size() < SD) m_stack.push_back((m_pc + 1) % 4096);
        else m_ovf = 1'b1;
        m_pc = int'(inB);
      end else if (absjump_en) begin
        m_pc = int'(inB);
      end else if (reljump_en) begin
        t = target[D-1] ? int'(target) - 4096 : int'(target);
        m_pc = (m_pc + t + 4096) % 4096;
      end else begin
        m_pc = (m_pc + 1) % 4096;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Continuous comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("model_pc", int'(prog_ctr), m_pc);
      chk("model_depth", int'(stack_depth), m_stack.size());
      chk("model_ovf", int'(stack_ovf), int'(m_ovf));
      chk("model_unf", int'(stack_unf), int'(m_unf));
    end
  end

  task automatic op(input bit rel, input bit ab, input bit cl, input bit rt,
                    input logic [D-1:0] tg, input logic [DW-1:0] ib);
    reljump_en = rel;
    absjump_en = ab;
    call_en    = cl;
    ret_en     = rt;
    target     = tg;
    inB        = ib;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op(0, 0, 0, 0, '0, '0);
  endtask

  task automatic lit(input string name, input int pc, input int dep, input int ovf, input int unf);
    chk({name, "_pc"}, int'(prog_ctr), pc);
    chk({name, "_depth"}, int'(stack_depth), dep);
    chk({name, "_ovf"}, int'(stack_ovf), ovf);
    chk({name, "_unf"}, int'(stack_unf), unf);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    idle();
    reset = 1'b0;
    lit("reset", 0, 0, 0, 0);

    for (int i = 1; i <= 5; i++) begin
      idle();
      chk("freerun_pc", int'(prog_ctr), i);
    end
    stall = 1'b1;
    repeat (3) begin
      op(1, 1, 1, 1, 12'h7, 8'h33);
      chk("stall_pc", int'(prog_ctr), 5);
    end
    stall = 1'b0;

    // Relative branch backwards and wrap-around
    op(0, 1, 0, 0, '0, 8'd10);
    chk("abs10", int'(prog_ctr), 10);
    op(1, 0, 0, 0, 12'hFFD, '0);
    chk("rel_minus3", int'(prog_ctr), 7);
    op(1, 0, 0, 0, 12'hFF8, '0);
    chk("rel_to_fff", int'(prog_ctr), 12'hFFF);
    idle();
    chk("wrap", int'(prog_ctr), 0);
    op(0, 1, 0, 0, '0, 8'hFF);
    chk("abs_zext", int'(prog_ctr), 12'h0FF);

    // Simple call/return
    op(0, 1, 0, 0, '0, 8'd20);
    op(0, 0, 1, 0, '0, 8'h40);
    lit("call", 12'h40, 1, 0, 0);
    idle();
    idle();
    chk("after_call2", int'(prog_ctr), 12'h42);
    op(0, 0, 0, 1, '0, '0);
    lit("ret", 21, 0, 0, 0);

    // Nested calls to overflow, returns to underflow
    op(0, 1, 0, 0, '0, 8'd1);
    for (int i = 0; i < 5; i++) op(0, 0, 1, 0, '0, 8'(8'h10 + i));
    lit("nest5", 12'h14, 4, 1, 0);
    op(0, 0, 0, 1, '0, '0);
    chk("ret1", int'(prog_ctr), 12'h13);
    op(0, 0, 0, 1, '0, '0);
    chk("ret2", int'(prog_ctr), 12'h12);
    op(0, 0, 0, 1, '0, '0);
    chk("ret3", int'(prog_ctr), 12'h11);
    op(0, 0, 0, 1, '0, '0);
    lit("ret4", 2, 0, 1, 0);
    op(0, 0, 0, 1, '0, '0);
    lit("ret5", 3, 0, 1, 1);

    // Priority resolution
    reset = 1'b1;
    idle();
    reset = 1'b0;
    lit("reset2", 0, 0, 0, 0);
    op(0, 1, 0, 0, '0, 8'h2F);
    op(0, 0, 1, 0, '0, 8'h50);
    op(1, 1, 1, 1, 12'h5, 8'h60);
    lit("all_en_ret", 12'h30, 0, 0, 0);
    op(1, 1, 1, 0, 12'h5, 8'h60);
    lit("call_wins", 12'h60, 1, 0, 0);
    op(1, 1, 0, 0, 12'h5, 8'h70);
    chk("abs_wins", int'(prog_ctr), 12'h70);
    op(1, 0, 0, 0, 12'h5, 8'h00);
    chk("rel_only", int'(prog_ctr), 12'h75);

    // Reset coincident with a call at depth 2
    op(0, 0, 1, 0, '0, 8'h80);
    chk("depth2", int'(stack_depth), 2);
    reset = 1'b1;
    op(0, 0, 1, 0, '0, 8'h90);
    reset = 1'b0;
    lit("reset_call", 0, 0, 0, 0);
    op(0, 0, 0, 1, '0, '0);
    lit("ret_after_reset", 1, 0, 0, 1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
